// File: rtl/bip_control_unit_pkg.sv
// Shared definitions for the BIP sequencing control unit: opcodes, FSM states
// and accumulator input mux selections.
package bip_control_unit_pkg;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;
  localparam logic [4:0] OP_BEQ  = 5'b01000;
  localparam logic [4:0] OP_BNE  = 5'b01001;
  localparam logic [4:0] OP_JMP  = 5'b01010;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [1:0] SEL_RAM = 2'd0;
  localparam logic [1:0] SEL_IMM = 2'd1;
  localparam logic [1:0] SEL_ALU = 2'd2;

endpackage

// File: rtl/bip_opcode_decoder.sv
// Combinational BIP opcode decoder: datapath controls plus branch-taken and
// halt indications for the sequencer.
module bip_opcode_decoder
  import bip_control_unit_pkg::*;
#(
  parameter int NB_OPCODE        = 5,
  parameter int NB_DECODER_SEL_A = 2
) (
  input  logic [NB_OPCODE-1:0]        i_opcode,
  input  logic                        i_accZero,
  output logic                        o_wrPc,
  output logic [NB_DECODER_SEL_A-1:0] o_selA,
  output logic                        o_selB,
  output logic                        o_wrAcc,
  output logic [NB_OPCODE-1:0]        o_op,
  output logic                        o_wrRam,
  output logic                        o_rdRam,
  output logic                        o_branch,
  output logic                        o_halt
);

  // Anything not listed falls through as a NOP with every control low.
  always_comb begin
    o_wrPc   = 1'b0;
    o_selA   = '0;
    o_selB   = 1'b0;
    o_wrAcc  = 1'b0;
    o_op     = '0;
    o_wrRam  = 1'b0;
    o_rdRam  = 1'b0;
    o_branch = 1'b0;
    o_halt   = 1'b0;
    case (i_opcode)
      NB_OPCODE'(OP_HLT): begin
        o_halt = 1'b1;
      end
      NB_OPCODE'(OP_STO): begin
        o_wrPc  = 1'b1;
        o_wrRam = 1'b1;
        o_op    = i_opcode;
      end
      NB_OPCODE'(OP_LD): begin
        o_wrPc  = 1'b1;
        o_selA  = NB_DECODER_SEL_A'(SEL_RAM);
        o_wrAcc = 1'b1;
        o_rdRam = 1'b1;
        o_op    = i_opcode;
      end
      NB_OPCODE'(OP_LDI): begin
        o_wrPc  = 1'b1;
        o_selA  = NB_DECODER_SEL_A'(SEL_IMM);
        o_wrAcc = 1'b1;
        o_op    = i_opcode;
      end
      NB_OPCODE'(OP_ADD), NB_OPCODE'(OP_SUB): begin
        o_wrPc  = 1'b1;
        o_selA  = NB_DECODER_SEL_A'(SEL_ALU);
        o_wrAcc = 1'b1;
        o_rdRam = 1'b1;
        o_op    = i_opcode;
      end
      NB_OPCODE'(OP_ADDI), NB_OPCODE'(OP_SUBI): begin
        o_wrPc  = 1'b1;
        o_selA  = NB_DECODER_SEL_A'(SEL_ALU);
        o_selB  = 1'b1;
        o_wrAcc = 1'b1;
        o_op    = i_opcode;
      end
      NB_OPCODE'(OP_BEQ): begin
        o_wrPc   = 1'b1;
        o_op     = i_opcode;
        o_branch = i_accZero;
      end
      NB_OPCODE'(OP_BNE): begin
        o_wrPc   = 1'b1;
        o_op     = i_opcode;
        o_branch = ~i_accZero;
      end
      NB_OPCODE'(OP_JMP): begin
        o_wrPc   = 1'b1;
        o_op     = i_opcode;
        o_branch = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bip_control_unit.sv
// BIP sequencing control unit: fetch/execute FSM, program counter, latched
// halt, single-step gating and a saturating executed-instruction counter.
module bip_control_unit
  import bip_control_unit_pkg::*;
#(
  parameter int NB_OPCODE        = 5,
  parameter int NB_OPERAND       = 11,
  parameter int NB_ADDR          = 11,
  parameter int NB_DECODER_SEL_A = 2,
  parameter int NB_COUNT         = 16
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [NB_OPCODE+NB_OPERAND-1:0] i_instr,
  input  logic                          i_acc_zero,
  input  logic                          i_step_mode,
  input  logic                          i_step,
  output logic [NB_ADDR-1:0]            o_pc,
  output logic [NB_OPERAND-1:0]         o_operand,
  output logic                          o_wrPc,
  output logic                          o_selB,
  output logic                          o_wrAcc,
  output logic                          o_wrRam,
  output logic                          o_rdRam,
  output logic [NB_DECODER_SEL_A-1:0]   o_selA,
  output logic [NB_OPCODE-1:0]          o_op,
  output logic                          o_halted,
  output logic [NB_COUNT-1:0]           o_count
);

  state_t state;
  state_t nextState;

  logic [NB_ADDR-1:0]          pc;
  logic [NB_COUNT-1:0]         count;
  logic [NB_OPCODE-1:0]        opcode;
  logic [NB_OPERAND-1:0]       operand;

  logic                        decWrPc;
  logic [NB_DECODER_SEL_A-1:0] decSelA;
  logic                        decSelB;
  logic                        decWrAcc;
  logic [NB_OPCODE-1:0]        decOp;
  logic                        decWrRam;
  logic                        decRdRam;
  logic                        decBranch;
  logic                        decHalt;

  assign opcode  = i_instr[NB_OPCODE+NB_OPERAND-1 -: NB_OPCODE];
  assign operand = i_instr[NB_OPERAND-1:0];

  bip_opcode_decoder #(
    .NB_OPCODE        (NB_OPCODE),
    .NB_DECODER_SEL_A (NB_DECODER_SEL_A)
  ) decoder (
    .i_opcode  (opcode),
    .i_accZero (i_acc_zero),
    .o_wrPc    (decWrPc),
    .o_selA    (decSelA),
    .o_selB    (decSelB),
    .o_wrAcc   (decWrAcc),
    .o_op      (decOp),
    .o_wrRam   (decWrRam),
    .o_rdRam   (decRdRam),
    .o_branch  (decBranch),
    .o_halt    (decHalt)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state <= FETCH;
    end else begin
      state <= nextState;
    end
  end

  // Controls are gated by EXEC so an async reset drops them in the same cycle.
  always_comb begin
    nextState = state;
    o_wrPc    = 1'b0;
    o_selA    = '0;
    o_selB    = 1'b0;
    o_wrAcc   = 1'b0;
    o_op      = '0;
    o_wrRam   = 1'b0;
    o_rdRam   = 1'b0;
    o_operand = '0;
    o_halted  = 1'b0;
    case (state)
      FETCH: begin
        if (!i_step_mode || i_step) begin
          nextState = EXEC;
        end
      end
      EXEC: begin
        nextState = decHalt ? HALT : FETCH;
        o_wrPc    = decWrPc;
        o_selA    = decSelA;
        o_selB    = decSelB;
        o_wrAcc   = decWrAcc;
        o_op      = decOp;
        o_wrRam   = decWrRam;
        o_rdRam   = decRdRam;
        o_operand = operand;
      end
      HALT: begin
        o_halted = 1'b1;
      end
      default: begin
        nextState = FETCH;
      end
    endcase
  end

  // PC advances on every non-halt EXEC, NOPs included, even with wrPc low.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      pc    <= '0;
      count <= '0;
    end else if (state == EXEC) begin
      if (!decHalt) begin
        pc <= decBranch ? operand[NB_ADDR-1:0] : pc + NB_ADDR'(1);
      end
      if (count != {NB_COUNT{1'b1}}) begin
        count <= count + NB_COUNT'(1);
      end
    end
  end

  assign o_pc    = pc;
  assign o_count = count;

endmodule
